alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 64-bit mainALU instance between NREQ requesters, e.g. the EX stage and the branch/address unit.
- Round-robin arbitration over per-requester valid/ready handshakes.
- Drives the ALU operand/operation inputs combinationally from the granted requester.
- Captures the ALU result into a one-entry response register, tagged with the requester ID.

Parameters:
- NREQ, 2, number of requesters (2..8).
- XLEN, 64, operand/result width; must match the ALU.
- IDW, $clog2(NREQ) (minimum 1), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  NREQ*4  per-requester ALU operation code.
- req_op1  in  NREQ*XLEN  per-requester operand 1.
- req_op2  in  NREQ*XLEN  per-requester operand 2.
- alu_operand  out  4  to the ALU operation select.
- alu_op1  out  XLEN  to ALU op1.
- alu_op2  out  XLEN  to ALU op2.
- alu_out  in  XLEN  ALU result (combinational).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that issued the response.
- rsp_data  out  XLEN  result.
- rsp_zero  out  1  zero flag.
- rsp_err  out  1  illegal operation code.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, RR pointer last=NREQ-1 (requester 0 wins first).
- Response state: EMPTY or FULL, equal to rsp_valid.
- can_accept = !rsp_valid | rsp_ready (drain and refill in the same cycle allowed).
- Grant:
  - Winner is the first valid requester scanning from last+1 mod NREQ upward with wrap.
  - Combinational from req_valid and last.
  - req_ready = onehot(winner) & {NREQ{can_accept & any_valid}}.
- ALU drive:
  - When a winner exists, alu_operand/op1/op2 = the winner's fields, even if can_accept=0.
  - With no valid requester, all three are driven 0.
- Accept (req_valid[i] & req_ready[i]):
  - Next edge: rsp_valid=1, rsp_id=i, rsp_data=alu_out, rsp_zero=alu_zero, last=i.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL.
  - Codes 7..15 are illegal: accepted normally, with rsp_data=0, rsp_zero=1, rsp_err=1; alu_out is ignored.
- Latency: exactly 1 cycle from accept to rsp_valid; sustained throughput 1 per cycle while rsp_ready=1.
- Backpressure: rsp_valid & !rsp_ready → all req_ready=0, response register and last held.
- Drain without a new accept: rsp_valid clears next edge; data, id and flags are held (don't-care).
- Requester protocol: a requester must hold valid and its fields stable until ready; a requester dropping valid before ready is legal and simply loses its slot.
- last updates only on accept; a requester that holds valid is granted within NREQ accepts.
- Reset asserted mid-operation clears the response immediately; the pending result is lost.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 wins whenever req_valid[0]=1. Requesters 1..NREQ-1 round-robin among themselves, and last tracks only their grants. Requester 0 can starve the others.
- Undefined: pure round-robin over all NREQ requesters, as above.

Decomposition:
- Package alu_arb_pkg:
  - alu_op_e enum (ADD..SRL, 4-bit).
  - ALU_OP_LAST=6.
  - XLEN_DEF=64.
  - function is_legal_op.
- Sub-module rr_pick:
  - Parameterised NREQ round-robin picker: inputs req and last, outputs onehot and idx.
  - Reused by later shared-resource arbiters (e.g. multiplier, memory port).

Test Plan:
- Single ADD: req0 op=0, op1=5, op2=7, rsp_ready=1 → req_ready[0] same cycle; next cycle rsp_valid=1, id=0, data=12, zero=0, err=0.
- Contention RR: both requesters valid continuously, rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 with no bubbles.
- Backpressure: hold rsp_ready=0 with a response FULL for 3 cycles → req_ready=0 and rsp_data stable; raise rsp_ready → drain and refill in the same edge.
- Zero and illegal op:
  - SUB 9-9 → data=0, zero=1, err=0.
  - op=9 with any operands → data=0, zero=1, err=1.
- Shift: SLL op1=1, op2=63 → data=0x8000_0000_0000_0000, zero=0.
- Reset mid-flight: assert rst_n=0 while rsp_valid=1 → rsp_valid=0 asynchronously; after release the first grant goes to requester 0. With ALU_ARB_FIXED_PRIO_EN defined, req0 and req1 valid continuously → only req0 is granted.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared ALU arbiter types, constants and op-code helper
package alu_arb_pkg;

  // Default datapath width of the shared mainALU
  localparam int XLEN_DEF = 64;

  // Highest legal operation code; everything above is rejected
  localparam int ALU_OP_LAST = 6;

  // ALU operation codes as seen on alu_operand
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6
  } alu_op_e;

  // True when the code maps onto an operation the ALU implements
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= 4'(ALU_OP_LAST));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - parameterised round-robin picker, reusable by shared-resource arbiters
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx
);

  logic found;
  int   pos;

  // First set request scanning upward from last+1, wrapping at NREQ
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = (int'(last) + k) % NREQ;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with a tagged one-entry response register (option: ALU_ARB_FIXED_PRIO_EN)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEF,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*XLEN-1:0] req_op1,
  input  logic [NREQ*XLEN-1:0] req_op2,
  output logic [3:0]           alu_operand,
  output logic [XLEN-1:0]      alu_op1,
  output logic [XLEN-1:0]      alu_op2,
  input  logic [XLEN-1:0]      alu_out,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_err
);

  logic [IDW-1:0]  last;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] rr_onehot;
  logic [IDW-1:0]  rr_idx;
  logic [NREQ-1:0] win_onehot;
  logic [IDW-1:0]  win_idx;
  logic            any_valid;
  logic            can_accept;
  logic            accept;
  logic            upd_last;
  logic            op_legal;

  // The register can take a new result when empty or being drained this cycle
  assign can_accept = !rsp_valid || rsp_ready;
  assign any_valid  = |req_valid;
  assign accept     = can_accept && any_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 bypasses rotation; the rest rotate among themselves
  assign pick_req   = {req_valid[NREQ-1:1], 1'b0};
  assign win_onehot = req_valid[0] ? NREQ'(1) : rr_onehot;
  assign win_idx    = req_valid[0] ? '0 : rr_idx;
  assign upd_last   = accept && !req_valid[0];
`else
  // Plain rotation over every requester
  assign pick_req   = req_valid;
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
  assign upd_last   = accept;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (pick_req),
    .last   (last),
    .onehot (rr_onehot),
    .idx    (rr_idx)
  );

  // Handshake is only offered to the winner and only when a slot is free
  assign req_ready = win_onehot & {NREQ{accept}};

  // Steer the winner's fields to the ALU even under backpressure; zero when idle
  always_comb begin
    alu_operand = '0;
    alu_op1     = '0;
    alu_op2     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) begin
        alu_operand = req_op[i*4 +: 4];
        alu_op1     = req_op1[i*XLEN +: XLEN];
        alu_op2     = req_op2[i*XLEN +: XLEN];
      end
    end
  end

  assign op_legal = is_legal_op(alu_operand);

  // Response register: capture on accept, clear valid on a plain drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win_idx;
      if (op_legal) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
      end else begin
        rsp_data <= '0;
        rsp_zero <= 1'b1;
        rsp_err  <= 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Rotation pointer moves only when a grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IDW'(NREQ - 1);
    end else if (upd_last) begin
      last <= win_idx;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int XLEN = 64;
  localparam int IDW  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ*XLEN-1:0] req_op1;
  logic [NREQ*XLEN-1:0] req_op2;
  logic [3:0]           alu_operand;
  logic [XLEN-1:0]      alu_op1;
  logic [XLEN-1:0]      alu_op2;
  logic [XLEN-1:0]      alu_out;
  logic                 alu_zero;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_data;
  logic                 rsp_zero;
  logic                 rsp_err;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .alu_operand (alu_operand),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err)
  );

  // Stand-in ALU; illegal codes return junk so the arbiter's override is visible
  always_comb begin
    case (alu_operand)
      4'd0:    alu_out = alu_op1 + alu_op2;
      4'd1:    alu_out = alu_op1 - alu_op2;
      4'd2:    alu_out = alu_op1 & alu_op2;
      4'd3:    alu_out = alu_op1 | alu_op2;
      4'd4:    alu_out = alu_op1 ^ alu_op2;
      4'd5:    alu_out = alu_op1 << alu_op2[5:0];
      4'd6:    alu_out = alu_op1 >> alu_op2[5:0];
      default: alu_out = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  logic [3:0]  fix_op[2];
  logic [63:0] fix_a[2];
  logic [63:0] fix_b[2];
  logic [63:0] fix_d[2];

  bit          m_valid;
  int          m_id;
  int          m_last;
  logic [63:0] m_data;

  function automatic int exp_grant(input logic [1:0] v, input int last);
    int j;
`ifdef ALU_ARB_FIXED_PRIO_EN
    j = last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
`else
    for (int k = 1; k <= 2; k++) begin
      j = (last + k) % 2;
      if (v[j]) return j;
    end
    return -1;
`endif
  endfunction

  task automatic step(input logic [1:0] v, input logic rdy, input string tag);
    int         g;
    logic [1:0] er;
    logic [63:0] ea;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rdy;
    #1;
    g  = exp_grant(v, m_last);
    er = ((!m_valid || rdy) && g >= 0) ? (2'b01 << g) : 2'b00;
    ea = 64'd0;
    if (g >= 0) ea = fix_a[g];
    check({tag, " req_ready"}, 64'(req_ready), 64'(er));
    check({tag, " alu_op1"}, alu_op1, ea);
    @(posedge clk);
    #1;
    if (er != 2'b00) begin
      m_valid = 1'b1;
      m_id    = g;
      m_data  = fix_d[g];
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (g != 0) m_last = g;
`else
      m_last = g;
`endif
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, " rsp_id"}, 64'(rsp_id), 64'(m_id));
      check({tag, " rsp_data"}, rsp_data, m_data);
    end
  endtask

  initial begin
    vecs[0] = '{4'd0, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0};
    vecs[1] = '{4'd1, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{4'd5, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    vecs[3] = '{4'd6, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b0};
    vecs[4] = '{4'd2, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'h0F00_0F00, 1'b0, 1'b0};
    vecs[5] = '{4'd3, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0};
    vecs[6] = '{4'd4, 64'hFFFF, 64'hFFFF, 64'd0, 1'b1, 1'b0};
    vecs[7] = '{4'd9, 64'd1234, 64'd5678, 64'd0, 1'b1, 1'b1};
    vecs[8] = '{4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1};
    vecs[9] = '{4'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    fix_op[0] = 4'd0; fix_a[0] = 64'd100;  fix_b[0] = 64'd23;   fix_d[0] = 64'd123;
    fix_op[1] = 4'd4; fix_a[1] = 64'hF0;   fix_b[1] = 64'h0F;   fix_d[1] = 64'hFF;

    req_valid = '0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_op1   = '0;
    req_op2   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_id", 64'(rsp_id), 64'd0);
    check("reset rsp_data", rsp_data, 64'd0);
    check("reset rsp_zero", 64'(rsp_zero), 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // Operation table through requester 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid     = 2'b01;
      rsp_ready     = 1'b1;
      req_op[3:0]   = vecs[i].op;
      req_op1[63:0] = vecs[i].a;
      req_op2[63:0] = vecs[i].b;
      #1;
      check($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'd1);
      check($sformatf("vec%0d alu_operand", i), 64'(alu_operand), 64'(vecs[i].op));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("vec%0d rsp_id", i), 64'(rsp_id), 64'd0);
      check($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].data);
      check($sformatf("vec%0d rsp_zero", i), 64'(rsp_zero), 64'(vecs[i].zero));
      check($sformatf("vec%0d rsp_err", i), 64'(rsp_err), 64'(vecs[i].err));
    end

    // Idle: ALU inputs forced to zero, response drains
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("idle alu_operand", 64'(alu_operand), 64'd0);
    check("idle alu_op1", alu_op1, 64'd0);
    check("idle alu_op2", alu_op2, 64'd0);
    check("idle req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("drain rsp_valid", 64'(rsp_valid), 64'd0);

    // Fresh reset so the pointer state is known, then fixed requester fields
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    req_op  = {fix_op[1], fix_op[0]};
    req_op1 = {fix_a[1], fix_a[0]};
    req_op2 = {fix_b[1], fix_b[0]};
    m_valid = 1'b0;
    m_id    = 0;
    m_last  = 1;
    m_data  = '0;

    step(2'b11, 1'b1, "first");
    for (int i = 0; i < 4; i++) step(2'b11, 1'b1, $sformatf("rr%0d", i));
    for (int i = 0; i < 4; i++) step(2'b11, 1'b0, $sformatf("bp%0d", i));
    step(2'b11, 1'b1, "refill");
    step(2'b10, 1'b0, "hold1");

    // Asynchronous reset while a response is held
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("async rst rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_last  = 1;

    step(2'b11, 1'b1, "postrst");
    step(2'b10, 1'b1, "only1");
    step(2'b11, 1'b1, "after1");
    step(2'b00, 1'b1, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
